// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide.
// Optional `MULDIV_FAST_MUL_EN` replaces the iterative multiply with a single-cycle product.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      muldiv_fn,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_r, state_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [XLEN:0]     hi_r;       // product high half / partial remainder
    logic [XLEN-1:0]   lo_r;       // product low half / dividend-quotient
    logic [XLEN-1:0]   addend_r;   // multiplicand or divisor magnitude
    logic [2:0]        fn_r;
    logic              neg_r;

    logic              accept_s, a_signed_s, b_signed_s, sa_s, sb_s;
    logic              is_div_s, is_rem_s, div_zero_s, ovf_s, special_s, fast_s;
    logic [XLEN-1:0]   ma_s, mb_s, special_res_s, fast_res_s, fix_res_s;
    logic [XLEN:0]     mul_sum_s, div_shift_s;
    logic [XLEN+1:0]   div_diff_s;
    logic [2*XLEN-1:0] prod_s, prod_fix_s;

    // Request decode: operand signedness, magnitudes and acceptance-time special cases
    always_comb begin
        accept_s   = start_i && ready_o && !flush_i;
        a_signed_s = (muldiv_fn == 3'b001) || (muldiv_fn == 3'b010) ||
                     (muldiv_fn == 3'b100) || (muldiv_fn == 3'b110);
        b_signed_s = (muldiv_fn == 3'b001) || (muldiv_fn == 3'b100) || (muldiv_fn == 3'b110);
        sa_s       = a_signed_s && a_i[XLEN-1];
        sb_s       = b_signed_s && b_i[XLEN-1];
        ma_s       = sa_s ? ({XLEN{1'b0}} - a_i) : a_i;
        mb_s       = sb_s ? ({XLEN{1'b0}} - b_i) : b_i;
        is_div_s   = muldiv_fn[2];
        is_rem_s   = muldiv_fn[2] && muldiv_fn[1];
        div_zero_s = is_div_s && (b_i == {XLEN{1'b0}});
        ovf_s      = is_div_s && !muldiv_fn[0] && (a_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (b_i == {XLEN{1'b1}});
        special_s  = div_zero_s || ovf_s;
        if (div_zero_s) begin
            special_res_s = is_rem_s ? a_i : {XLEN{1'b1}};
        end else if (ovf_s) begin
            special_res_s = is_rem_s ? {XLEN{1'b0}} : a_i;
        end else begin
            special_res_s = {XLEN{1'b0}};
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] a_ext_s, b_ext_s, fprod_s;

    // Single-cycle product; sign extension to 2*XLEN gives the correct modular result
    always_comb begin
        a_ext_s    = {{XLEN{a_signed_s && a_i[XLEN-1]}}, a_i};
        b_ext_s    = {{XLEN{b_signed_s && b_i[XLEN-1]}}, b_i};
        fprod_s    = a_ext_s * b_ext_s;
        fast_s     = !muldiv_fn[2];
        fast_res_s = (muldiv_fn[1:0] == 2'b00) ? fprod_s[XLEN-1:0] : fprod_s[2*XLEN-1:XLEN];
    end
`else
    // Iterative multiply only: no fast path
    always_comb begin
        fast_s     = 1'b0;
        fast_res_s = {XLEN{1'b0}};
    end
`endif

    // One iteration step of each algorithm plus the sign fix-up and result select
    always_comb begin
        mul_sum_s   = {1'b0, hi_r[XLEN-1:0]} + (lo_r[0] ? {1'b0, addend_r} : {(XLEN+1){1'b0}});
        div_shift_s = {hi_r[XLEN-1:0], lo_r[XLEN-1]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, addend_r};
        prod_s      = {hi_r[XLEN-1:0], lo_r};
        prod_fix_s  = neg_r ? ({(2*XLEN){1'b0}} - prod_s) : prod_s;
        case (fn_r)
            3'b000:         fix_res_s = prod_fix_s[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:         fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
            3'b100, 3'b101: fix_res_s = neg_r ? ({XLEN{1'b0}} - lo_r) : lo_r;
            3'b110, 3'b111: fix_res_s = neg_r ? ({XLEN{1'b0}} - hi_r[XLEN-1:0]) : hi_r[XLEN-1:0];
            default:        fix_res_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state logic; flush overrides every state
    always_comb begin
        state_next_s = state_r;
        if (flush_i) begin
            state_next_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (accept_s) begin
                        state_next_s = (special_s || fast_s) ? S_DONE : S_CALC;
                    end else begin
                        state_next_s = S_IDLE;
                    end
                end
                S_CALC: begin
                    if (cnt_r == CNT_W'(1)) begin
                        state_next_s = S_FIX;
                    end else begin
                        state_next_s = S_CALC;
                    end
                end
                S_FIX:   state_next_s = S_DONE;
                default: state_next_s = S_IDLE;
            endcase
        end
    end

    // State register, registered status outputs and datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            ready_o  <= 1'b1;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            result_o <= {XLEN{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            hi_r     <= {(XLEN+1){1'b0}};
            lo_r     <= {XLEN{1'b0}};
            addend_r <= {XLEN{1'b0}};
            fn_r     <= 3'b000;
            neg_r    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ready_o <= (state_next_s == S_IDLE) || (state_next_s == S_DONE);
            busy_o  <= (state_next_s == S_CALC) || (state_next_s == S_FIX);
            done_o  <= (state_next_s == S_DONE);
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (accept_s) begin
                        fn_r     <= muldiv_fn;
                        neg_r    <= is_rem_s ? sa_s : (sa_s ^ sb_s);
                        hi_r     <= {(XLEN+1){1'b0}};
                        lo_r     <= is_div_s ? ma_s : mb_s;
                        addend_r <= is_div_s ? mb_s : ma_s;
                        cnt_r    <= CNT_W'(XLEN);
                        if (special_s) begin
                            result_o <= special_res_s;
                        end else if (fast_s) begin
                            result_o <= fast_res_s;
                        end
                    end
                end
                S_CALC: begin
                    if (!flush_i) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                        if (fn_r[2]) begin
                            // Restoring step: keep the difference only when it did not borrow
                            if (!div_diff_s[XLEN+1]) begin
                                hi_r <= div_diff_s[XLEN:0];
                                lo_r <= {lo_r[XLEN-2:0], 1'b1};
                            end else begin
                                hi_r <= div_shift_s;
                                lo_r <= {lo_r[XLEN-2:0], 1'b0};
                            end
                        end else begin
                            hi_r <= {1'b0, mul_sum_s[XLEN:1]};
                            lo_r <= {mul_sum_s[0], lo_r[XLEN-1:1]};
                        end
                    end
                end
                S_FIX: begin
                    if (!flush_i) begin
                        result_o <= fix_res_s;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
